// File: rtl/dac_out_pkg.sv
// Shared definitions for the multichannel DAC output block.
// Holds the state encoding, sample coding helpers and width helpers.
// No ports; imported by dac_multich_output and dac_sample_fifo.
package dac_out_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Widest sample the helpers below can carry; callers cast down to DATA_W.
  localparam int MAX_W = 32;

  // FIFO read/write pointer index width; pointers carry one extra wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Coded midscale: 1000..0 in offset binary, 0000..0 in two's complement.
  function automatic logic [MAX_W-1:0] mid_code(input int unsigned w, input logic offset_binary);
    logic [MAX_W-1:0] m;
    m = '0;
    if (offset_binary) m[w-1] = 1'b1;
    return m;
  endfunction

  // Offset binary is two's complement with the sign bit inverted.
  function automatic logic [MAX_W-1:0] code_sample(input logic [MAX_W-1:0] x, input int unsigned w,
                                                   input logic offset_binary);
    logic [MAX_W-1:0] y;
    y = x;
    if (offset_binary) y[w-1] = ~y[w-1];
    return y;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Single-clock elastic sample FIFO, one per DAC channel; dout shows the head combinationally.
// Ports: push/din write, pop reads head, flush empties, full/empty/count reflect registered pointers.
// Pushes when full and pops when empty are ignored; full does not see a same-cycle pop.
module dac_sample_fifo
  import dac_out_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]     wr_q, rd_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Pointers differ only in the wrap bit when the FIFO is full.
  assign count   = wr_q - rd_q;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (wr_q == rd_q);
  assign dout    = mem_q[rd_q[AW-1:0]];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dac_multich_output.sv
// Multichannel DAC output stage: per-channel FIFOs, prefill/run control, independent or interleaved lanes.
// Ports: din_* valid/ready per channel in; da_data/da_sel registered (1 cycle after pop), da_clk/da_wrt forward clk_sample.
// din_ready drops when a channel FIFO is full; an empty FIFO in RUN emits midscale and sets a sticky underrun flag.
module dac_multich_output
  import dac_out_pkg::*;
#(
  parameter int DATA_W        = 14,
  parameter int NUM_CH        = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int PREFILL       = 4,
  parameter int OFFSET_BINARY = 1
) (
  input  logic                                       clk_sample,
  input  logic                                       rst,
  input  logic                                       en,
  input  logic                                       mode_interleave,
  input  logic [NUM_CH*DATA_W-1:0]                   din_data,
  input  logic [NUM_CH-1:0]                          din_valid,
  output logic [NUM_CH-1:0]                          din_ready,
  input  logic                                       underrun_clr,
  output logic [NUM_CH*DATA_W-1:0]                   da_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] da_sel,
  output logic                                       da_clk,
  output logic                                       da_wrt,
  output logic [NUM_CH-1:0]                          underrun,
  output logic                                       state_run
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = ptr_w(FIFO_DEPTH) + 1;
  localparam logic [DATA_W-1:0] MID = DATA_W'(mid_code(DATA_W, OFFSET_BINARY != 0));

  function automatic logic [DATA_W-1:0] code_w(input logic [DATA_W-1:0] x);
    return DATA_W'(code_sample(MAX_W'(x), DATA_W, OFFSET_BINARY != 0));
  endfunction

  state_t                    state_q, state_d;
  logic                      mode_q, mode_d;
  logic [SEL_W-1:0]          rr_q, rr_d, sel_q, sel_d;
  logic [NUM_CH*DATA_W-1:0]  lanes_q, lanes_d;
  logic [NUM_CH-1:0]         ur_q, ur_d, ur_set;

  logic [DATA_W-1:0]         head [NUM_CH];
  logic [CNT_W-1:0]          cnt  [NUM_CH];
  logic [NUM_CH-1:0]         full, empty, pop, prefilled;
  logic                      flush;

  assign flush = (state_q == IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign din_ready[g] = (state_q != IDLE) & ~full[g];
    assign prefilled[g] = (cnt[g] >= CNT_W'(PREFILL));

    dac_sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk_sample),
      .rst   (rst),
      .push  (din_valid[g] & din_ready[g]),
      .pop   (pop[g]),
      .flush (flush),
      .din   (din_data[g*DATA_W +: DATA_W]),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .count (cnt[g])
    );
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rr_d    = '0;
    sel_d   = '0;
    lanes_d = {NUM_CH{MID}};
    pop     = '0;
    ur_set  = '0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = FILL;
          mode_d  = mode_interleave;
        end
      end
      FILL: begin
        if (!en)             state_d = IDLE;
        else if (&prefilled) state_d = RUN;
      end
      RUN: begin
        // The pop in the cycle en falls still happens; the flush follows in IDLE.
        if (!en) state_d = IDLE;
        if (mode_q) begin
          // rr advances even on an underrun so channel slots stay fixed in time.
          rr_d  = (rr_q == SEL_W'(NUM_CH - 1)) ? '0 : rr_q + 1'b1;
          sel_d = rr_q;
          if (empty[rr_q]) begin
            ur_set[rr_q] = 1'b1;
          end else begin
            pop[rr_q]            = 1'b1;
            lanes_d[0 +: DATA_W] = code_w(head[rr_q]);
          end
        end else begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (empty[c]) begin
              ur_set[c] = 1'b1;
            end else begin
              pop[c]                       = 1'b1;
              lanes_d[c*DATA_W +: DATA_W] = code_w(head[c]);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh underrun wins over a clear in the same cycle.
    ur_d = (ur_q & ~{NUM_CH{underrun_clr}}) | ur_set;
  end

  always_ff @(posedge clk_sample or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      rr_q    <= '0;
      sel_q   <= '0;
      lanes_q <= {NUM_CH{MID}};
      ur_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      lanes_q <= lanes_d;
      ur_q    <= ur_d;
    end
  end

  assign da_data   = lanes_q;
  assign da_sel    = sel_q;
  assign underrun  = ur_q;
  assign state_run = (state_q == RUN);
  assign da_clk    = clk_sample;
  assign da_wrt    = clk_sample;

endmodule

// File: tb/tb_dac_multich_output.sv
// Directed plus randomized bench for dac_multich_output against a queue-based reference model.
module tb_dac_multich_output;

  localparam int DATA_W        = 14;
  localparam int NUM_CH        = 2;
  localparam int FIFO_DEPTH    = 8;
  localparam int PREFILL       = 4;
  localparam int OFFSET_BINARY = 1;

  logic                      clk_sample = 1'b0;
  logic                      rst;
  logic                      en;
  logic                      mode_interleave;
  logic [NUM_CH*DATA_W-1:0]  din_data;
  logic [NUM_CH-1:0]         din_valid;
  logic [NUM_CH-1:0]         din_ready;
  logic                      underrun_clr;
  logic [NUM_CH*DATA_W-1:0]  da_data;
  logic [0:0]                da_sel;
  logic                      da_clk;
  logic                      da_wrt;
  logic [NUM_CH-1:0]         underrun;
  logic                      state_run;

  dac_multich_output #(
    .DATA_W        (DATA_W),
    .NUM_CH        (NUM_CH),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .PREFILL       (PREFILL),
    .OFFSET_BINARY (OFFSET_BINARY)
  ) dut (
    .clk_sample      (clk_sample),
    .rst             (rst),
    .en              (en),
    .mode_interleave (mode_interleave),
    .din_data        (din_data),
    .din_valid       (din_valid),
    .din_ready       (din_ready),
    .underrun_clr    (underrun_clr),
    .da_data         (da_data),
    .da_sel          (da_sel),
    .da_clk          (da_clk),
    .da_wrt          (da_wrt),
    .underrun        (underrun),
    .state_run       (state_run)
  );

  always #5 clk_sample = ~clk_sample;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_FILL, M_RUN} mst_t;
  mst_t              mst;
  int                mmode;
  int                rr;
  int                q [NUM_CH][$];
  int                exp_lane [NUM_CH];
  int                exp_sel;
  bit [NUM_CH-1:0]   exp_ur;
  bit [NUM_CH-1:0]   last_acc;

  int il_lane [4] = '{'h2100, 'h2200, 'h2101, 'h2201};
  int il_sel  [4] = '{0, 1, 0, 1};

  function automatic int mid_val();
    return (OFFSET_BINARY != 0) ? (1 << (DATA_W - 1)) : 0;
  endfunction

  // Offset binary = two's complement value shifted up by half scale, modulo full scale.
  function automatic int code(int x);
    if (OFFSET_BINARY != 0) return (x + (1 << (DATA_W - 1))) % (1 << DATA_W);
    return x;
  endfunction

  function automatic logic [NUM_CH*DATA_W-1:0] pack_lanes();
    logic [NUM_CH*DATA_W-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = DATA_W'(exp_lane[c]);
    return v;
  endfunction

  task automatic model_reset();
    mst    = M_IDLE;
    mmode  = 0;
    rr     = 0;
    exp_sel = 0;
    exp_ur = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      q[c].delete();
      exp_lane[c] = mid_val();
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic check_outputs();
    chk($sformatf("da_data@%0d", cyc), da_data, pack_lanes());
    chk($sformatf("da_sel@%0d", cyc), da_sel, exp_sel);
    chk($sformatf("underrun@%0d", cyc), underrun, exp_ur);
    chk($sformatf("state_run@%0d", cyc), state_run, (mst == M_RUN));
  endtask

  // One clock: check din_ready, advance the model over the edge, then check registered outputs.
  task automatic tick();
    bit [NUM_CH-1:0] rdy;
    bit [NUM_CH-1:0] set;
    mst_t            nxt;
    for (int c = 0; c < NUM_CH; c++) rdy[c] = (mst != M_IDLE) && (q[c].size() < FIFO_DEPTH);
    chk($sformatf("din_ready@%0d", cyc), din_ready, rdy);
    set = '0;
    nxt = mst;
    case (mst)
      M_IDLE: begin
        for (int c = 0; c < NUM_CH; c++) begin
          q[c].delete();
          exp_lane[c] = mid_val();
        end
        exp_sel = 0;
        rr = 0;
        if (en) begin
          nxt = M_FILL;
          mmode = mode_interleave;
        end
      end
      M_FILL: begin
        bit all_ok;
        all_ok = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          exp_lane[c] = mid_val();
          if (q[c].size() < PREFILL) all_ok = 1'b0;
        end
        exp_sel = 0;
        rr = 0;
        if (!en) nxt = M_IDLE;
        else if (all_ok) nxt = M_RUN;
      end
      default: begin
        if (mmode == 0) begin
          exp_sel = 0;
          for (int c = 0; c < NUM_CH; c++) begin
            if (q[c].size() == 0) begin
              exp_lane[c] = mid_val();
              set[c] = 1'b1;
            end else begin
              exp_lane[c] = code(q[c].pop_front());
            end
          end
        end else begin
          for (int c = 0; c < NUM_CH; c++) exp_lane[c] = mid_val();
          exp_sel = rr;
          if (q[rr].size() == 0) set[rr] = 1'b1;
          else exp_lane[0] = code(q[rr].pop_front());
          rr = (rr + 1) % NUM_CH;
        end
        if (!en) nxt = M_IDLE;
      end
    endcase
    last_acc = din_valid & rdy;
    for (int c = 0; c < NUM_CH; c++)
      if (last_acc[c]) q[c].push_back(int'(din_data[c*DATA_W +: DATA_W]));
    exp_ur = (exp_ur & ~{NUM_CH{underrun_clr}}) | set;
    mst = nxt;
    @(posedge clk_sample);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic set_ch(input int c, input bit v, input int d);
    din_valid[c] = v;
    din_data[c*DATA_W +: DATA_W] = DATA_W'(d);
  endtask

  task automatic idle_inputs();
    din_valid    = '0;
    underrun_clr = 1'b0;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        set_ch(c, ($urandom_range(0, 3) != 0), int'($urandom_range(0, (1 << DATA_W) - 1)));
      underrun_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle_inputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_da_data"}, da_data, {14'h2000, 14'h2000});
    chk({tag, "_din_ready"}, din_ready, 2'b00);
    chk({tag, "_underrun"}, underrun, 2'b00);
    chk({tag, "_state_run"}, state_run, 1'b0);
    chk({tag, "_da_sel"}, da_sel, 1'b0);
  endtask

  int d0, d1;

  initial begin
    rst = 1'b1;
    en = 1'b0;
    mode_interleave = 1'b0;
    din_data = '0;
    din_valid = '0;
    underrun_clr = 1'b0;
    #2;
    model_reset();
    check_reset_values("reset");
    @(posedge clk_sample);
    #1;
    rst = 1'b0;

    // Independent mode prefill and first samples.
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, 1 + i);
      set_ch(1, 1'b1, 'h3FFF - i);
      tick();
    end
    idle_inputs();
    tick();
    chk("enter_run", state_run, 1'b1);
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, 5 + i);
      tick();
      chk($sformatf("lane0_seq%0d", i), da_data[DATA_W-1:0], 'h2001 + i);
      chk($sformatf("lane1_seq%0d", i), da_data[2*DATA_W-1:DATA_W], 'h1FFF - i);
    end
    d0 = 9;
    set_ch(0, 1'b1, d0++);
    tick();
    chk("lane1_drained_mid", da_data[2*DATA_W-1:DATA_W], 'h2000);
    chk("underrun_ch1_set", underrun, 2'b10);
    // Clear in the same cycle as a new underrun: flag must stay set.
    underrun_clr = 1'b1;
    set_ch(0, 1'b1, d0++);
    tick();
    chk("clr_vs_set", underrun[1], 1'b1);
    underrun_clr = 1'b0;
    d1 = 'h10;
    set_ch(0, 1'b1, d0++); set_ch(1, 1'b1, d1++);
    tick();
    set_ch(0, 1'b1, d0++); set_ch(1, 1'b1, d1++);
    tick();
    underrun_clr = 1'b1;
    set_ch(0, 1'b1, d0++); set_ch(1, 1'b1, d1++);
    tick();
    chk("clr_effective", underrun, 2'b00);
    idle_inputs();
    run_random(150);

    // Drop en mid-RUN.
    en = 1'b0;
    tick();
    tick();
    chk("drop_en_idle", state_run, 1'b0);
    chk("drop_en_mid", da_data, {14'h2000, 14'h2000});

    // Interleave mode.
    mode_interleave = 1'b1;
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, 'h100 + i);
      set_ch(1, 1'b1, 'h200 + i);
      tick();
    end
    idle_inputs();
    mode_interleave = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("il_lane0_%0d", i), da_data[DATA_W-1:0], il_lane[i]);
      chk($sformatf("il_sel_%0d", i), da_sel, il_sel[i]);
      chk($sformatf("il_lane1_%0d", i), da_data[2*DATA_W-1:DATA_W], 'h2000);
    end
    run_random(150);
    en = 1'b0;
    tick();
    tick();

    // Fill ch0 to full while ch1 stays empty; ch0 source holds each word until taken.
    en = 1'b1;
    tick();
    d0 = 'h0A00;
    for (int i = 0; i < 12; i++) begin
      set_ch(0, 1'b1, d0);
      tick();
      if (last_acc[0]) d0++;
    end
    chk("full_ready0", din_ready[0], 1'b0);
    chk("full_stays_fill", state_run, 1'b0);
    chk("full_accepted", d0, 'h0A00 + FIFO_DEPTH);
    for (int i = 0; i < 24; i++) begin
      set_ch(0, 1'b1, d0);
      set_ch(1, (i < 4), 'h0B00 + i);
      tick();
      if (last_acc[0]) d0++;
    end
    idle_inputs();
    en = 1'b0;
    tick();

    // Reset asserted in the middle of FILL.
    en = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      set_ch(0, 1'b1, 'h0C00 + i);
      set_ch(1, 1'b1, 'h0D00 + i);
      tick();
    end
    rst = 1'b1;
    #2;
    model_reset();
    check_reset_values("midfill_rst");
    idle_inputs();
    en = 1'b0;
    @(posedge clk_sample);
    #1;
    rst = 1'b0;
    tick();
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      set_ch(0, 1'b1, 'h0E00 + i);
      set_ch(1, 1'b1, 'h0F00 + i);
      tick();
    end
    idle_inputs();
    tick();
    tick();
    chk("fresh_lane0", da_data[DATA_W-1:0], 'h2E00);
    chk("fresh_lane1", da_data[2*DATA_W-1:DATA_W], 'h2F00);
    tick();
    tick();
    tick();
    tick();
    chk("fresh_drained_ur", underrun, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
